// File: rtl/packet_stream_pkg.sv
// Shared FSM state type and byte-mask helper for the packet stream reader.
package packet_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Valid-byte mask of a packet's final word; a zero remainder means the word is full.
    function automatic logic [7:0] keep_from_rem(input logic [2:0] rem, input int unsigned bytes);
        logic [7:0] mask_s;
        if (rem == 3'd0) begin
            mask_s = (8'h01 << bytes) - 8'h01;
        end else begin
            mask_s = (8'h01 << rem) - 8'h01;
        end
        return mask_s;
    endfunction

endpackage

// File: rtl/bsg_two_fifo.sv
// Two-entry FIFO used as the reader's output queue; ready_o low means full.
module bsg_two_fifo #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i
);

    logic [width_p-1:0] mem_r [2];
    logic               head_r;
    logic               tail_r;
    logic [1:0]         count_r;
    logic               enq_s;
    logic               deq_s;

    assign ready_o = (count_r != 2'd2);
    assign v_o     = (count_r != 2'd0);
    assign enq_s   = v_i & ready_o;
    assign deq_s   = yumi_i & v_o;
    assign data_o  = mem_r[head_r];

    // Pointers and occupancy
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_r  <= 1'b0;
            tail_r  <= 1'b0;
            count_r <= 2'd0;
        end else begin
            if (enq_s) begin
                tail_r <= ~tail_r;
            end
            if (deq_s) begin
                head_r <= ~head_r;
            end
            count_r <= count_r + {1'b0, enq_s} - {1'b0, deq_s};
        end
    end

    // Storage, written only on enqueue
    always_ff @(posedge clk_i) begin
        if (enq_s) begin
            mem_r[tail_r] <= data_i;
        end
    end

endmodule

// File: rtl/packet_stream_reader_chk.sv
// Simulation-only protocol invariants of the packet stream reader.
module packet_stream_reader_chk #(
    parameter int els_p        = 2048,
    parameter int size_width_p = 12
) (
    input logic                    clk_i,
    input logic                    reset_i,
    input logic [size_width_p-1:0] size,
    input logic                    rdata_arrive,
    input logic                    q_ready,
    input logic                    ack,
    input logic                    avail
);

    // Check size range, queue overflow and ack-without-packet every cycle
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (size <= size_width_p'(els_p))
                else $error("reader: latched size exceeds slot size");
            assert (!(rdata_arrive && !q_ready))
                else $error("reader: read data returned into a full queue");
            assert (!(ack && !avail))
                else $error("reader: ack raised with no packet available");
        end
    end

endmodule

// File: rtl/packet_stream_reader.sv
// Drains packets from the slot buffer read port into a byte-keep valid/ready stream,
// absorbing the one-cycle read latency with a credit-managed two-entry queue.
module packet_stream_reader
    import packet_stream_pkg::*;
#(
    parameter int data_width_p = 64,
    parameter int els_p        = 2048,
    localparam int bytes_lp             = data_width_p / 8,
    localparam int addr_width_lp        = $clog2(els_p),
    localparam int packet_size_width_lp = $clog2(els_p + 1)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic                            packet_avail_i,
    output logic                            packet_ack_o,
    output logic                            packet_rvalid_o,
    output logic [addr_width_lp-1:0]        packet_raddr_o,
    output logic [1:0]                      packet_rdata_size_o,
    input  logic [data_width_p-1:0]         packet_rdata_i,
    input  logic [packet_size_width_lp-1:0] packet_rsize_i,
    output logic [data_width_p-1:0]         tx_data_o,
    output logic [bytes_lp-1:0]             tx_keep_o,
    output logic                            tx_last_o,
    output logic                            tx_v_o,
    input  logic                            tx_ready_i
);

    localparam int lg_bytes_lp = $clog2(bytes_lp);
    localparam int psw_lp      = packet_size_width_lp;
    localparam int q_width_lp  = data_width_p + bytes_lp + 1;

    state_e                  state_r, state_n;
    logic [psw_lp-1:0]       size_r, words_r, word_cnt_r, words_s;
    logic [addr_width_lp-1:0] raddr_r;
    logic                    inflight_r, meta_last_r;
    logic [bytes_lp-1:0]     meta_keep_r, keep_s;
    logic [7:0]              keep_rem_s;
    logic                    issue_s, issue_last_s, credit_s, pop_s, last_hs_s;
    logic                    q_ready_s, q_v_s;
    logic [q_width_lp-1:0]   q_data_s;
    logic [2:0]              occupancy_s;

    assign words_s      = (packet_rsize_i + psw_lp'(bytes_lp - 1)) >> lg_bytes_lp;
    assign keep_rem_s   = keep_from_rem(3'(size_r[lg_bytes_lp-1:0]), bytes_lp);
    assign issue_last_s = (word_cnt_r == (words_r - psw_lp'(1)));
    assign keep_s       = issue_last_s ? keep_rem_s[bytes_lp-1:0] : {bytes_lp{1'b1}};

    // Queued entries plus the read in flight, less the beat leaving this cycle, must leave room
    assign occupancy_s  = 3'({~q_ready_s, q_v_s & q_ready_s}) + 3'(inflight_r);
    assign credit_s     = (occupancy_s < (3'd2 + 3'(pop_s)));
    assign pop_s        = q_v_s & tx_ready_i;
    assign last_hs_s    = pop_s & q_data_s[0];

    assign packet_rvalid_o     = issue_s;
    assign packet_raddr_o      = raddr_r;
    assign packet_rdata_size_o = 2'(lg_bytes_lp);

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (packet_avail_i && (packet_rsize_i != {psw_lp{1'b0}})) state_n = READ;
                else state_n = IDLE;
            end
            READ: begin
                if (issue_s && issue_last_s) state_n = DRAIN;
                else state_n = READ;
            end
            DRAIN: begin
                if (last_hs_s) state_n = IDLE;
                else state_n = DRAIN;
            end
            default: state_n = IDLE;
        endcase
    end

    // Read issue and slot release
    always_comb begin
        issue_s      = 1'b0;
        packet_ack_o = 1'b0;
        case (state_r)
            IDLE:    packet_ack_o = packet_avail_i && (packet_rsize_i == {psw_lp{1'b0}});
            READ:    issue_s = credit_s;
            DRAIN:   packet_ack_o = last_hs_s;
            default: begin
                issue_s      = 1'b0;
                packet_ack_o = 1'b0;
            end
        endcase
    end

    // Packet bookkeeping and per-beat metadata that travels with the read
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            size_r      <= {psw_lp{1'b0}};
            words_r     <= {psw_lp{1'b0}};
            word_cnt_r  <= {psw_lp{1'b0}};
            raddr_r     <= {addr_width_lp{1'b0}};
            inflight_r  <= 1'b0;
            meta_keep_r <= {bytes_lp{1'b0}};
            meta_last_r <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                meta_keep_r <= keep_s;
                meta_last_r <= issue_last_s;
            end
            if ((state_r == IDLE) && packet_avail_i) begin
                size_r     <= packet_rsize_i;
                words_r    <= words_s;
                word_cnt_r <= {psw_lp{1'b0}};
                raddr_r    <= {addr_width_lp{1'b0}};
            end else if (issue_s) begin
                word_cnt_r <= word_cnt_r + psw_lp'(1);
                raddr_r    <= raddr_r + addr_width_lp'(bytes_lp);
            end
        end
    end

    bsg_two_fifo #(.width_p(q_width_lp)) out_q (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .data_i  ({packet_rdata_i, meta_keep_r, meta_last_r}),
        .v_i     (inflight_r),
        .ready_o (q_ready_s),
        .data_o  (q_data_s),
        .v_o     (q_v_s),
        .yumi_i  (pop_s)
    );

    // Stream outputs read as zero whenever no beat is offered
    always_comb begin
        tx_v_o = q_v_s;
        if (q_v_s) begin
            tx_data_o = q_data_s[q_width_lp-1 -: data_width_p];
            tx_keep_o = q_data_s[bytes_lp:1];
            tx_last_o = q_data_s[0];
        end else begin
            tx_data_o = {data_width_p{1'b0}};
            tx_keep_o = {bytes_lp{1'b0}};
            tx_last_o = 1'b0;
        end
    end

    packet_stream_reader_chk #(.els_p(els_p), .size_width_p(psw_lp)) chk (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .size         (size_r),
        .rdata_arrive (inflight_r),
        .q_ready      (q_ready_s),
        .ack          (packet_ack_o),
        .avail        (packet_avail_i)
    );

endmodule
